// File: rtl/selecting_result_judge.sv
// selecting_result_judge
//   Watches the selecting machine's seven sequencer run flags. Once every
//   sequencer has been started and then stopped, waits for the code bus to
//   settle, captures it, grades the five numeric digits into a prize level,
//   adds that level's points to a saturating score and blinks the win LED
//   until the next round is armed.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   flag[6:0]    sequencer run flags (1 = running)
//   code[27:0]   [27:24] char, [23:20] letter, [19:0] digits d4..d0
//   result_valid one-cycle pulse when a new result is published
//   prize_level  grade of the last judged round (0-5)
//   score        cumulative points, saturating at 255
//   win_led      blinks with half-period BLINK_CYC while showing a win
//   code_err     last captured round held a digit above 9
//
// Optional build macro
//   JUDGE_BONUS_EN  char 4 with letter A doubles the round's points.

// Per-digit lane: how many of the five digits equal digit IDX.
module srj_digit_mult #(
  parameter int NUM_DIG = 5,
  parameter int DIG_W   = 4,
  parameter int CNT_W   = 3,
  parameter int IDX     = 0
) (
  input  logic [NUM_DIG-1:0][DIG_W-1:0] digs,
  output logic [CNT_W-1:0]              mult
);
  always_comb begin
    mult = '0;
    for (int j = 0; j < NUM_DIG; j++)
      if (digs[j] == digs[IDX]) mult = mult + CNT_W'(1);
  end
endmodule

module selecting_result_judge #(
  parameter int SETTLE_CYC = 16,
  parameter int BLINK_CYC  = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  flag,
  input  logic [27:0] code,
  output logic        result_valid,
  output logic [2:0]  prize_level,
  output logic [7:0]  score,
  output logic        win_led,
  output logic        code_err
);
  localparam int NUM_DIG = 5;
  localparam int DIG_W   = 4;
  localparam int CNT_W   = $clog2(NUM_DIG + 1);
  localparam int SET_W   = $clog2(SETTLE_CYC + 1);
  localparam int BLK_W   = 28;
  localparam logic [6:0]       FLAG_ALL   = 7'h7F;
  localparam logic [SET_W-1:0] SET_LOAD   = SET_W'(SETTLE_CYC - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_CYC - 1);

  typedef enum logic [2:0] {IDLE, ARMED, SETTLE, JUDGE, SHOW} state_t;

  typedef struct packed {
    logic       err;
    logic [2:0] level;
    logic [6:0] pts;
  } grade_t;

  state_t                         state_q, state_d;
  logic [SET_W-1:0]               settle_cnt;
  logic [BLK_W-1:0]               blink_cnt;
  logic [27:0]                    cap_q;
  logic [NUM_DIG-1:0][DIG_W-1:0]  digs;
  logic [NUM_DIG-1:0][CNT_W-1:0]  mult;
  logic [CNT_W-1:0]               max_m;
  logic                           any_err;
  logic                           straight;
  grade_t                         grade;
  logic [7:0]                     score_nx;

  assign digs = cap_q[19:0];

  // ---------------------------------------------------------------- grading
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_mult
    srj_digit_mult #(
      .NUM_DIG(NUM_DIG), .DIG_W(DIG_W), .CNT_W(CNT_W), .IDX(g)
    ) u_mult (
      .digs(digs),
      .mult(mult[g])
    );
  end

  // Largest lane count is the largest multiplicity of any digit value.
  always_comb begin
    max_m = '0;
    for (int i = 0; i < NUM_DIG; i++)
      if (mult[i] > max_m) max_m = mult[i];
  end

  // Digit index 0 is d0 (lowest nibble); a straight climbs from d4 to d0,
  // so every lower digit is one more than the digit above it.
  always_comb begin
    any_err  = 1'b0;
    straight = 1'b1;
    for (int i = 0; i < NUM_DIG; i++)
      if (digs[i] > DIG_W'(9)) any_err = 1'b1;
    for (int i = 0; i < NUM_DIG - 1; i++)
      if (digs[i] != digs[i+1] + DIG_W'(1)) straight = 1'b0;
  end

  always_comb begin
    grade = '0;
    if (any_err) begin
      grade.err = 1'b1;
    end else if (straight) begin
      grade.level = 3'd5;
      grade.pts   = 7'd30;
    end else begin
      case (max_m)
        CNT_W'(5): begin grade.level = 3'd4; grade.pts = 7'd100; end
        CNT_W'(4): begin grade.level = 3'd3; grade.pts = 7'd20;  end
        CNT_W'(3): begin grade.level = 3'd2; grade.pts = 7'd5;   end
        CNT_W'(2): begin grade.level = 3'd1; grade.pts = 7'd1;   end
        default:   begin grade.level = 3'd0; grade.pts = 7'd0;   end
      endcase
    end
  end

  // ------------------------------------------------------------- score add
`ifdef JUDGE_BONUS_EN
  logic       bonus;
  logic [9:0] pts_eff;
  logic [9:0] sum;
  assign bonus    = (cap_q[27:24] == 4'h4) && (cap_q[23:20] == 4'hA);
  assign pts_eff  = bonus ? {2'b00, grade.pts, 1'b0} : {3'b000, grade.pts};
  assign sum      = {2'b00, score} + pts_eff;
  assign score_nx = (sum > 10'd255) ? 8'hFF : sum[7:0];
`else
  logic [8:0] sum;
  logic [7:0] unused_cap;
  assign unused_cap = cap_q[27:20];
  assign sum        = {1'b0, score} + {2'b00, grade.pts};
  assign score_nx   = sum[8] ? 8'hFF : sum[7:0];
`endif

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (flag == FLAG_ALL) state_d = ARMED;
      ARMED:  if (flag == 7'h00)    state_d = SETTLE;
      SETTLE: begin
        if (flag != 7'h00)          state_d = ARMED;
        else if (settle_cnt == '0)  state_d = JUDGE;
      end
      JUDGE:  state_d = SHOW;
      SHOW:   if (flag == FLAG_ALL) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_cnt   <= '0;
      blink_cnt    <= '0;
      cap_q        <= '0;
      result_valid <= 1'b0;
      prize_level  <= '0;
      score        <= '0;
      win_led      <= 1'b0;
      code_err     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state_q)
        ARMED: if (flag == 7'h00) settle_cnt <= SET_LOAD;
        SETTLE: begin
          if (flag == 7'h00) begin
            if (settle_cnt == '0) cap_q      <= code;
            else                  settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        JUDGE: begin
          prize_level  <= grade.level;
          code_err     <= grade.err;
          score        <= score_nx;
          result_valid <= 1'b1;
          win_led      <= (grade.level != 3'd0);
          blink_cnt    <= '0;
        end
        SHOW: begin
          if (flag == FLAG_ALL) begin
            win_led   <= 1'b0;
            blink_cnt <= '0;
          end else if (prize_level != 3'd0) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              win_led   <= ~win_led;
            end else begin
              blink_cnt <= blink_cnt + BLK_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_selecting_result_judge.sv
module tb_selecting_result_judge;
  localparam int S = 4;
  localparam int B = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  flag = 7'h00;
  logic [27:0] code = 28'h0;
  logic        result_valid;
  logic [2:0]  prize_level;
  logic [7:0]  score;
  logic        win_led;
  logic        code_err;

  int n_chk  = 0;
  int n_pass = 0;
  int m_score = 0;
  int m_lvl   = 0;
  bit m_err   = 0;

  selecting_result_judge #(.SETTLE_CYC(S), .BLINK_CYC(B)) dut (
    .clk(clk), .rst(rst), .flag(flag), .code(code),
    .result_valid(result_valid), .prize_level(prize_level), .score(score),
    .win_led(win_led), .code_err(code_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference grading: histogram of digit values, straight test on integers.
  task automatic model_grade(input logic [27:0] c, output int lvl, output bit err, output int pts);
    int d[5];
    int h[16];
    int m;
    int tab[6];
    tab = '{0, 1, 5, 20, 100, 30};
    for (int v = 0; v < 16; v++) h[v] = 0;
    err = 0;
    m = 0;
    for (int i = 0; i < 5; i++) begin
      d[i] = int'(c[4*i +: 4]);
      if (d[i] > 9) err = 1;
      h[d[i]]++;
    end
    for (int v = 0; v < 16; v++) if (h[v] > m) m = h[v];
    if (err) lvl = 0;
    else if (d[3] == d[4] + 1 && d[2] == d[3] + 1 && d[1] == d[2] + 1 && d[0] == d[1] + 1) lvl = 5;
    else lvl = m - 1;
    pts = err ? 0 : tab[lvl];
`ifdef JUDGE_BONUS_EN
    if (c[27:24] == 4'h4 && c[23:20] == 4'hA) pts = pts * 2;
`endif
  endtask

  task automatic run_round(input logic [27:0] c, input bit blink);
    int pts;
    int kmax;
    flag = 7'h7F;
    step(1);
    chk("led_off_arm", win_led, 1'b0);
    flag = 7'h00;
    code = c;
    step(S + 1);
    chk("rv_early", result_valid, 1'b0);
    step(1);
    model_grade(c, m_lvl, m_err, pts);
    m_score = (m_score + pts > 255) ? 255 : m_score + pts;
    chk("rv_pulse", result_valid, 1'b1);
    chk("level", prize_level, m_lvl);
    chk("err", code_err, m_err);
    chk("score", score, m_score);
    chk("led_start", win_led, m_lvl > 0);
    code = $urandom;
    kmax = blink ? 2 * B + 2 : 1;
    for (int k = 1; k <= kmax; k++) begin
      step(1);
      if (k == 1) begin
        chk("rv_one_cycle", result_valid, 1'b0);
        chk("level_held", prize_level, m_lvl);
      end
      chk("led_blink", win_led, (m_lvl > 0) ? (((k / B) % 2) == 0) : 0);
    end
  endtask

  task automatic watch_quiet(input string tag, input int n);
    bit seen;
    seen = 0;
    repeat (n) begin
      step(1);
      if (result_valid) seen = 1;
    end
    chk(tag, seen, 1'b0);
  endtask

  function automatic logic [19:0] rnd_digits();
    logic [19:0] r;
    int mode;
    int v;
    int n;
    for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    mode = $urandom_range(0, 3);
    case (mode)
      1: begin
        v = $urandom_range(0, 5);
        for (int i = 0; i < 5; i++) r[4*(4-i) +: 4] = 4'(v + i);
      end
      2: begin
        n = $urandom_range(1, 4);
        for (int i = 1; i <= n; i++) r[4*i +: 4] = r[3:0];
      end
      3: begin
        v = $urandom_range(0, 4);
        r[4*v +: 4] = 4'($urandom_range(10, 15));
      end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [27:0] c;
    // reset state
    step(2);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_level", prize_level, 3'd0);
    chk("rst_score", score, 8'd0);
    chk("rst_led", win_led, 1'b0);
    chk("rst_err", code_err, 1'b0);
    rst = 1'b1;
    step(1);

    // build score 37: L5 + L2 + L1 + L1
    run_round(28'h0034567, 0);
    run_round(28'h0011123, 0);
    run_round(28'h0012213, 0);
    run_round(28'h0055012, 0);
    chk("score_37", score, 8'd37);

    // asynchronous reset in the middle of SHOW
    step(2);
    #2 rst = 1'b0;
    #1;
    chk("arst_rv", result_valid, 1'b0);
    chk("arst_level", prize_level, 3'd0);
    chk("arst_score", score, 8'd0);
    chk("arst_led", win_led, 1'b0);
    chk("arst_err", code_err, 1'b0);
    #2 rst = 1'b1;
    m_score = 0;
    step(1);
    // IDLE ignores partial and all-zero flags
    flag = 7'h3C;
    watch_quiet("idle_partial", 3);
    flag = 7'h00;
    watch_quiet("idle_zero", S + 4);

    // directed rounds
    run_round(28'h0077777, 1);
    run_round(28'h0034567, 0);
    run_round(28'h0012213, 1);
    run_round(28'h009A999, 1);

    // settle aborted by a sequencer restarting
    flag = 7'h7F;
    step(1);
    flag = 7'h00;
    step(2);
    flag = 7'h08;
    watch_quiet("abort_no_rv", S + 3);
    chk("abort_score_held", score, m_score);
    run_round(28'h0044321, 0);

    // randomized rounds, with stray flags ignored while showing
    for (int r = 0; r < 25; r++) begin
      c = {4'($urandom_range(0, 4)), 4'($urandom_range(10, 15)), rnd_digits()};
      run_round(c, (r % 6) == 0);
      flag = 7'($urandom_range(0, 126));
      watch_quiet("show_stray_flag", 3);
      chk("show_level_held", prize_level, m_lvl);
    end

    // saturation
    run_round(28'h0077777, 0);
    run_round(28'h0077777, 0);
    run_round(28'h0077777, 0);
    chk("sat_255", score, 8'd255);
    run_round(28'h0022292, 0);
    chk("sat_hold", score, 8'd255);

`ifdef JUDGE_BONUS_EN
    #2 rst = 1'b0;
    #4 rst = 1'b1;
    m_score = 0;
    step(1);
    run_round(28'h4A55555, 0);
    chk("bonus_200", score, 8'd200);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/selecting_result_judge.md
Name: selecting_result_judge

Overview:
- Downstream consumer of the selecting machine's stop flags and 28-bit code bus; `code` bits 27:24 are the lattice character, 23:20 the letter, 19:0 five numeric digits.
- Waits until every sequencer has been stopped, lets the code settle, then captures the code.
- Grades the five numeric digits into a prize level and adds points to a saturating running score.
- Drives a blinking win LED until a new round begins.

Parameters:
- SETTLE_CYC, 16: clk cycles `flag` must stay all-zero before the code is captured (minimum 2).
- BLINK_CYC, 12500000: win_led half-period in clk cycles (minimum 1); the counter is 28 bits wide.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset (0 = reset).
- flag  in  7  per-sequencer run flags; 1 = running, 0 = stopped.
- code  in  28  sequencer outputs: [27:24] char 0-4, [23:20] letter A-F, [19:16]..[3:0] digits d4..d0, each 0-9.
- result_valid  out  1  one-cycle pulse when a new result is published.
- prize_level  out  3  grade of the last judged round, 0-5.
- score  out  8  cumulative points, saturating at 255.
- win_led  out  1  blinks while showing a winning result.
- code_err  out  1  last captured round contained a numeric digit greater than 9.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, settle/blink counters=0, capture register=0, and all outputs 0 (result_valid, prize_level, score, win_led, code_err).
- State IDLE:
  - flag==7'h7F → ARMED.
  - Any other value: stay in IDLE.
- State ARMED:
  - flag==7'h00 → SETTLE, with settle counter loaded to SETTLE_CYC-1.
  - Otherwise stay in ARMED.
- State SETTLE:
  - Decrement the settle counter each cycle while flag==0.
  - Any nonzero flag bit → back to ARMED; nothing is captured.
  - Counter==0 with flag==0 → capture code into an internal register → JUDGE.
- State JUDGE, exactly one cycle; all of the following happen on the same edge:
  - Register prize_level and code_err.
  - Update score.
  - Pulse result_valid for one cycle.
  - Go to SHOW.
- State SHOW:
  - If prize_level>0, win_led toggles every BLINK_CYC cycles, starting at 1 on SHOW entry.
  - If prize_level==0, win_led=0.
  - flag==7'h7F → ARMED with win_led=0; prize_level, score and code_err are held.
- Latency: from the first cycle flag==0 is sampled in ARMED to result_valid = SETTLE_CYC+2 cycles.
- Grading: digits d4..d0 are taken from the captured register.
  - Any digit >9: code_err=1, level 0, no points added.
  - Straight (d3=d4+1, d2=d3+1, d1=d2+1, d0=d1+1): level 5. Straight has priority over all other levels.
  - Otherwise, m = maximum multiplicity of any digit value among the five digits:
    - m=5 → level 4.
    - m=4 → level 3.
    - m=3 → level 2.
    - m=2 → level 1.
    - m=1 → level 0.
- Points per level:
  - L0 = 0, L1 = 1, L2 = 5, L3 = 20, L4 = 100, L5 = 30.
  - score_next = min(score + points, 255), computed in 9 bits, then saturated.
- Score is retained across rounds; only rst clears it.
- flag values that are neither all-ones nor all-zero are ignored in IDLE and SHOW.

Optional Feature:
- Macro: JUDGE_BONUS_EN.
- When defined: if captured char==4'h4 and letter==4'hA, points are doubled before saturation, in 10 bits.
- The doubling also applies when points are 0, i.e. it adds nothing.
- When undefined: char and letter bits are ignored; no bonus logic is built.

Test Plan:
- Reset with rst=0 mid-SHOW (score=37) → all outputs 0 immediately and state IDLE; the next round starts from score 0.
- flag 7F→00, code[19:0]=20'h77777, SETTLE_CYC=4 → result_valid at cycle 6, prize_level=4, score 0→100, win_led toggles every BLINK_CYC (set to 8 in the bench).
- code[19:0]=20'h34567 → prize_level=5 (not 1), +30. Then code 20'h12213 → level 1 (m=2), +1.
- Drop flag to 0 for 2 cycles, then set flag[3]=1 during SETTLE → no result_valid; return to ARMED. A later all-zero flag is judged normally.
- Score preloaded near the limit via three L4 rounds (300 → 255), then an L3 round → score stays 255.
- code[19:0]=20'h9A999 → code_err=1, prize_level=0, score unchanged.
- With JUDGE_BONUS_EN and code=28'h4A55555 → level 4, +200.
